// File: rtl/roi_pkg.sv
// Shared types and helpers for the ROI store-and-forward packet FIFO.
package roi_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } type_wr_state;

  localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

  // Occupancy of two free-running pointers of width ptr_w (modulo 2**ptr_w).
  function automatic logic [31:0] ptr_occupancy(input logic [31:0] wr_ptr,
                                                input logic [31:0] rd_ptr,
                                                input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/roi_pkt_ram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module roi_pkt_ram #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are not reset; only committed entries are ever read.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/roi_axis_pkt_fifo.sv
// Store-and-forward packet FIFO between the ROI cropper and an AXI-Stream sink.
// Optional packet statistics ports are enabled with `define ROI_PKT_STATS_EN.
module roi_axis_pkt_fifo
  import roi_pkg::*;
#(
  parameter int BIT_DATA_O = 8,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [BIT_DATA_O-1:0] tdata_i,
  input  logic                  tvalid_i,
  input  logic                  tlast_i,
  output logic [BIT_DATA_O-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic                  m_tuser_o,
  output logic                  overflow_o
`ifdef ROI_PKT_STATS_EN
  ,
  output logic [15:0]           pkt_ok_cnt_o,
  output logic [15:0]           pkt_drop_cnt_o
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_INC = PTR_W'(1);

  type_wr_state state_q, state_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             sof_q, sof_d;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_en_s;
  logic                  commit_s;
  logic                  drop_evt_s;
  logic                  rd_hs_s;
  logic [BIT_DATA_O:0]   wr_data_s;
  logic [BIT_DATA_O:0]   rd_data_s;

  // Full is judged against the pre-edge read pointer: a same-cycle read frees nothing.
  assign full_s    = (ptr_occupancy(32'(wr_ptr_q), 32'(rd_ptr_q), PTR_W) == 32'(DEPTH));
  assign empty_s   = (rd_ptr_q == cm_ptr_q);
  assign wr_data_s = {tlast_i, tdata_i};

  roi_pkt_ram #(
    .WIDTH (BIT_DATA_O + 1),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i    (clk_i),
    .wr_en_i  (wr_en_s),
    .wr_addr_i(wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i(wr_data_s),
    .rd_addr_i(rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o(rd_data_s)
  );

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS: begin
        if (tvalid_i && full_s && !tlast_i) begin
          state_d = DROP;
        end else begin
          state_d = PASS;
        end
      end
      DROP: begin
        if (tvalid_i && tlast_i) begin
          state_d = PASS;
        end else begin
          state_d = DROP;
        end
      end
      default: state_d = PASS;
    endcase
  end

  // A beat hitting full rewinds the speculative pointer to the last committed packet.
  always_comb begin
    wr_en_s    = 1'b0;
    commit_s   = 1'b0;
    drop_evt_s = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    overflow_d = overflow_q;
    case (state_q)
      PASS: begin
        if (tvalid_i) begin
          if (!full_s) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_INC;
            if (tlast_i) begin
              commit_s = 1'b1;
              cm_ptr_d = wr_ptr_q + PTR_INC;
            end else begin
              cm_ptr_d = cm_ptr_q;
            end
          end else begin
            drop_evt_s = 1'b1;
            wr_ptr_d   = cm_ptr_q;
            overflow_d = 1'b1;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      DROP: begin
        wr_en_s = 1'b0;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    m_tvalid_o = !empty_s;
    m_tdata_o  = rd_data_s[BIT_DATA_O-1:0];
    m_tlast_o  = rd_data_s[BIT_DATA_O];
    m_tuser_o  = m_tvalid_o & sof_q;
    rd_hs_s    = m_tvalid_o & m_tready_i;
    if (rd_hs_s) begin
      rd_ptr_d = rd_ptr_q + PTR_INC;
      sof_d    = m_tlast_o;
    end else begin
      rd_ptr_d = rd_ptr_q;
      sof_d    = sof_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      sof_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      sof_q      <= sof_d;
    end
  end

  assign overflow_o = overflow_q;

`ifdef ROI_PKT_STATS_EN
  logic [15:0] pkt_ok_cnt_q, pkt_ok_cnt_d;
  logic [15:0] pkt_drop_cnt_q, pkt_drop_cnt_d;

  // Saturating packet counters.
  always_comb begin
    if (commit_s && (pkt_ok_cnt_q != STAT_CNT_MAX)) begin
      pkt_ok_cnt_d = pkt_ok_cnt_q + 16'd1;
    end else begin
      pkt_ok_cnt_d = pkt_ok_cnt_q;
    end
    if (drop_evt_s && (pkt_drop_cnt_q != STAT_CNT_MAX)) begin
      pkt_drop_cnt_d = pkt_drop_cnt_q + 16'd1;
    end else begin
      pkt_drop_cnt_d = pkt_drop_cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      pkt_ok_cnt_q   <= 16'd0;
      pkt_drop_cnt_q <= 16'd0;
    end else begin
      pkt_ok_cnt_q   <= pkt_ok_cnt_d;
      pkt_drop_cnt_q <= pkt_drop_cnt_d;
    end
  end

  assign pkt_ok_cnt_o   = pkt_ok_cnt_q;
  assign pkt_drop_cnt_o = pkt_drop_cnt_q;
`endif

endmodule

// File: doc/roi_axis_pkt_fifo.md
Name: roi_axis_pkt_fifo

Overview:
- Downstream stage of the ROI cropper: consumes its cropped pixel stream (tdata/tvalid/tlast, no backpressure).
- Re-emits the stream as a backpressured AXI-Stream master (tready) toward DMA/display.
- Store-and-forward packet FIFO: a ROI packet becomes visible downstream only once its tlast beat is stored.
- A packet that overflows the FIFO is discarded whole, so downstream never sees a truncated ROI.

Parameters:
- BIT_DATA_O, 8: pixel width.
- DEPTH, 1024: FIFO entries; must be a power of 2. ADDR_W = $clog2(DEPTH).

Ports:
- clk_i  input  1  clock.
- arst_i  input  1  reset; active-high, synchronous to clk_i (sampled only on rising edge).
- tdata_i  input  BIT_DATA_O  cropped pixel from ROI stage.
- tvalid_i  input  1  pixel valid; no ready is returned upstream.
- tlast_i  input  1  last pixel of ROI packet.
- m_tdata_o  output  BIT_DATA_O  output pixel.
- m_tvalid_o  output  1  output beat valid.
- m_tready_i  input  1  downstream ready.
- m_tlast_o  output  1  last beat of packet.
- m_tuser_o  output  1  start-of-packet: high on first beat of each packet.
- overflow_o  output  1  sticky; set on any dropped packet; cleared only by reset.

Behaviour:
- Storage: DEPTH x (BIT_DATA_O+1) array holding {last, data}.
- Pointers, each ADDR_W+1 bits, wrap naturally:
  - wr_ptr: speculative write pointer.
  - cm_ptr: commit pointer.
  - rd_ptr: read pointer.
- full = (wr_ptr - rd_ptr) == DEPTH. Output empty = (rd_ptr == cm_ptr).
- Reset:
  - wr_ptr = cm_ptr = rd_ptr = 0; state = PASS; overflow_o = 0; sof flag = 1.
  - m_tvalid_o = 0.
  - Array contents are don't-care.
  - Reset mid-packet discards all stored and partial data.
- Write FSM, states PASS and DROP:
  - PASS, tvalid_i & !full: write entry at wr_ptr, then wr_ptr+1. If tlast_i, also cm_ptr <= wr_ptr+1 on the same edge.
  - PASS, tvalid_i & full: beat discarded; wr_ptr <= cm_ptr (rewind partial packet); overflow_o <= 1. If tlast_i, stay PASS; else go to DROP.
  - DROP: discard every valid beat. On a valid tlast_i beat, go to PASS. No writes occur in DROP.
  - Packets longer than DEPTH always overflow and are dropped.
- Read side (first-word-fall-through):
  - m_tvalid_o = !empty.
  - m_tdata_o / m_tlast_o = array[rd_ptr] (combinational read).
  - Handshake m_tvalid_o & m_tready_i: rd_ptr+1.
  - m_tvalid_o must not drop, and m_tdata_o must not change, while m_tready_i is low.
- Start of packet:
  - Registered sof flag; m_tuser_o = m_tvalid_o & sof.
  - On handshake: sof <= m_tlast_o.
- Latency: tlast beat written at edge N → m_tvalid_o high in cycle after N. First pixel of a packet cannot emerge before its tlast is stored.
- Simultaneous read/write/commit in one cycle is legal.
  - full uses the pre-edge rd_ptr; a read in the same cycle does not free a slot for that cycle's write.
  - A rewind never crosses rd_ptr, since cm_ptr ≥ rd_ptr always.
- Single-beat packet (tvalid_i & tlast_i first) is legal: m_tuser_o and m_tlast_o high together.

Optional Feature:
- Macro ROI_PKT_STATS_EN.
- Defined: adds output ports pkt_ok_cnt_o[15:0] (increments on each commit) and pkt_drop_cnt_o[15:0] (increments on each overflow event). Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package roi_pkg: type_wr_state enum {PASS, DROP}; function for pointer occupancy.
- Sub-module roi_pkt_ram: simple dual-port array (1 write port, 1 asynchronous read port), parameterised on width/depth. Top level holds pointers, FSM and read handshake.

Test Plan:
- Basic: DEPTH=16, 4-beat packet 0x10..0x13 with tlast on 0x13, m_tready_i=1 → m_tvalid_o rises the cycle after the tlast write; 4 beats out; m_tuser_o on 0x10; m_tlast_o on 0x13.
- Backpressure: same packet, m_tready_i toggling 1,0,0,1… → data held stable while stalled; order and values 0x10..0x13 intact; no loss.
- Overflow: DEPTH=16, m_tready_i=0, send 20-beat packet → nothing emitted; overflow_o=1; wr_ptr==cm_ptr==0. Next 3-beat packet 0xA0..0xA2 then m_tready_i=1 → only 0xA0..0xA2 emitted.
- Tlast-on-full: fill 16 entries with a committed 8-beat packet plus 8 beats, then tlast beat arrives while full → partial packet dropped; FSM stays PASS; the next packet is accepted immediately.
- Single-beat and wrap: 40 one-beat packets, m_tready_i=1, DEPTH=16 → 40 outputs, each with m_tuser_o = m_tlast_o = 1; pointers wrap correctly.
- Reset mid-packet: assert arst_i after 2 beats of a packet → m_tvalid_o=0 next cycle; subsequent packet emitted cleanly. With ROI_PKT_STATS_EN: counts pkt_ok_cnt_o=1, pkt_drop_cnt_o=0.
